// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: CDB tag encoding, functional-unit counts and the
// broadcast record that reservation stations and the register status table snoop.
package tomasulo_pkg;

  localparam int TAG_W     = 4;
  localparam int DATA_W    = 32;
  localparam int NUM_ADD   = 3;
  localparam int NUM_MUL   = 2;
  localparam int NUM_UNITS = NUM_ADD + NUM_MUL;

  typedef logic [TAG_W-1:0] tag_t;

  // Tag 0 means "no producer": the operand is already available.
  localparam tag_t TAG_NONE = 4'd0;
  localparam tag_t TAG_ADD1 = 4'd1;
  localparam tag_t TAG_ADD2 = 4'd2;
  localparam tag_t TAG_ADD3 = 4'd3;
  localparam tag_t TAG_MUL1 = 4'd4;
  localparam tag_t TAG_MUL2 = 4'd5;

  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-request and CDB broadcast bundle between the functional units and the
// CDB arbiter. Units use the master modport; the arbiter uses slave.
interface cdb_arbiter_if #(
  parameter int NUM_UNITS = 5,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4
);

  logic [NUM_UNITS-1:0]        req_valid;
  logic [NUM_UNITS*DATA_W-1:0] req_data;
  logic [NUM_UNITS-1:0]        grant;
  logic                        cdb_valid;
  logic [TAG_W-1:0]            cdb_tag;
  logic [DATA_W-1:0]           cdb_data;
  logic [15:0]                 cdb_count;

  modport master (
    output req_valid, req_data,
    input  grant, cdb_valid, cdb_tag, cdb_data, cdb_count
  );

  modport slave (
    input  req_valid, req_data,
    output grant, cdb_valid, cdb_tag, cdb_data, cdb_count
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start,
// wrapping modulo N. Produces a one-hot grant and the winner's index.
module rr_pick #(
  parameter  int N     = 5,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int j;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one finished result per cycle and broadcasts it on a
// registered CDB. Define CDB_MUL_PRIORITY_EN to give multipliers priority over adders.
module cdb_arbiter #(
  parameter int NUM_UNITS = tomasulo_pkg::NUM_UNITS,
  parameter int DATA_W    = tomasulo_pkg::DATA_W,
  parameter int TAG_W     = tomasulo_pkg::TAG_W
) (
  input  logic          clk,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);

  import tomasulo_pkg::*;

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] pick_gnt;
  logic [IDX_W-1:0]     winner;
  logic                 any_req;
  logic                 transfer;
  logic [DATA_W-1:0]    win_data;

`ifdef CDB_MUL_PRIORITY_EN
  localparam int ADD_W = (NUM_ADD > 1) ? $clog2(NUM_ADD) : 1;
  localparam int MUL_W = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;

  logic [ADD_W-1:0]   rr_add, add_idx;
  logic [MUL_W-1:0]   rr_mul, mul_idx;
  logic [NUM_ADD-1:0] add_gnt;
  logic [NUM_MUL-1:0] mul_gnt;
  logic               add_found, mul_found;

  rr_pick #(.N(NUM_ADD)) u_pick_add (
    .req   (bus.req_valid[NUM_ADD-1:0]),
    .start (rr_add),
    .gnt   (add_gnt),
    .idx   (add_idx),
    .found (add_found)
  );

  rr_pick #(.N(NUM_MUL)) u_pick_mul (
    .req   (bus.req_valid[NUM_UNITS-1:NUM_ADD]),
    .start (rr_mul),
    .gnt   (mul_gnt),
    .idx   (mul_idx),
    .found (mul_found)
  );

  // Any requesting multiplier beats every adder.
  always_comb begin
    if (mul_found) begin
      pick_gnt = {mul_gnt, {NUM_ADD{1'b0}}};
      winner   = IDX_W'(NUM_ADD) + IDX_W'(mul_idx);
    end else begin
      pick_gnt = {{NUM_MUL{1'b0}}, add_gnt};
      winner   = IDX_W'(add_idx);
    end
  end

  assign any_req = add_found | mul_found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_add <= '0;
      rr_mul <= '0;
    end else if (transfer) begin
      if (mul_found)
        rr_mul <= (mul_idx == MUL_W'(NUM_MUL - 1)) ? '0 : mul_idx + MUL_W'(1);
      else
        rr_add <= (add_idx == ADD_W'(NUM_ADD - 1)) ? '0 : add_idx + ADD_W'(1);
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  rr_pick #(.N(NUM_UNITS)) u_pick (
    .req   (bus.req_valid),
    .start (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (winner),
    .found (any_req)
  );

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (transfer)
      rr_ptr <= (winner == IDX_W'(NUM_UNITS - 1)) ? '0 : winner + IDX_W'(1);
  end
`endif

  // Grant is suppressed during reset so nothing transfers while the CDB is cleared.
  assign bus.grant = reset ? '0 : pick_gnt;
  assign transfer  = any_req & ~reset;
  assign win_data  = bus.req_data[winner*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= TAG_NONE;
      bus.cdb_data  <= '0;
      bus.cdb_count <= '0;
    end else begin
      bus.cdb_valid <= transfer;
      bus.cdb_tag   <= transfer ? TAG_W'(winner) + TAG_W'(1) : TAG_NONE;
      bus.cdb_data  <= transfer ? win_data : '0;
      if (transfer && bus.cdb_count != 16'hFFFF)
        bus.cdb_count <= bus.cdb_count + 16'd1;
    end
  end

  req_valid_known: assert property (@(posedge clk) disable iff (reset)
                                    !$isunknown(bus.req_valid));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: the driver pushes hand-computed
// broadcasts, a negedge monitor pops and compares them against the CDB.
module tb_cdb_arbiter;

  localparam int NU = 5;
  localparam int DW = 32;
  localparam int TW = 4;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [15:0]   count;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_UNITS(NU), .DATA_W(DW), .TAG_W(TW)) bus ();

  cdb_arbiter #(.NUM_UNITS(NU), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Unit i always presents 0x11*(i+1): ADD1=0x11 .. MUL2=0x55.
  function automatic logic [DW-1:0] unit_data(input int i);
    return DW'(32'h11 * (i + 1));
  endfunction

  task automatic push_exp(input int unit);
    exp_t e;
    exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
    e.tag   = TW'(unit + 1);
    e.data  = unit_data(unit);
    e.count = exp_count;
    sb.push_back(e);
  endtask

  // One clock of stimulus: drive requests, check the same-cycle grant, queue the broadcast.
  task automatic cycle(input logic [NU-1:0] req, input logic [NU-1:0] exp_gnt);
    @(negedge clk);
    bus.req_valid = req;
    #1;
    check("grant", bus.grant, exp_gnt);
    for (int i = 0; i < NU; i++)
      if (exp_gnt[i]) push_exp(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset         = 1'b1;
    bus.req_valid = '0;
    sb.delete();
    exp_count = '0;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("cdb_valid", bus.cdb_valid, 1);
      check("cdb_tag",   bus.cdb_tag,   e.tag);
      check("cdb_data",  bus.cdb_data,  e.data);
      check("cdb_count", bus.cdb_count, e.count);
    end else begin
      check("idle_valid",    bus.cdb_valid, 0);
      check("idle_tag_data", {bus.cdb_tag, bus.cdb_data}, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = {unit_data(4), unit_data(3), unit_data(2), unit_data(1), unit_data(0)};
    exp_count     = '0;
    reset         = 1'b0;
    #1 reset      = 1'b1;

    // Reset state: grant held low even with a request present.
    @(negedge clk);
    bus.req_valid = 5'b00001;
    #1;
    check("reset_grant",     bus.grant,     0);
    check("reset_cdb_valid", bus.cdb_valid, 0);
    check("reset_cdb_count", bus.cdb_count, 0);
    @(negedge clk);
    #2;
    reset         = 1'b0;
    bus.req_valid = '0;

    // Single request from ADD1.
    cycle(5'b00001, 5'b00001);
    cycle(5'b00000, 5'b00000);

    // All five units request; each withdraws once granted.
    do_reset();
`ifdef CDB_MUL_PRIORITY_EN
    cycle(5'b11111, 5'b01000);
    cycle(5'b10111, 5'b10000);
    cycle(5'b00111, 5'b00001);
    cycle(5'b00110, 5'b00010);
    cycle(5'b00100, 5'b00100);
`else
    cycle(5'b11111, 5'b00001);
    cycle(5'b11110, 5'b00010);
    cycle(5'b11100, 5'b00100);
    cycle(5'b11000, 5'b01000);
    cycle(5'b10000, 5'b10000);
`endif
    cycle(5'b00000, 5'b00000);

    // Fairness: ADD1 re-requests every cycle, ADD3 once -> tags 1,3,1.
    cycle(5'b00101, 5'b00001);
    cycle(5'b00101, 5'b00100);
    cycle(5'b00001, 5'b00001);
    cycle(5'b00000, 5'b00000);

    // Wrap-around: pointer to 4, then MUL2 and ADD1; pointer ends at 1 so ADD2 beats ADD1.
    cycle(5'b01000, 5'b01000);
    cycle(5'b10001, 5'b10000);
    cycle(5'b00001, 5'b00001);
    cycle(5'b00011, 5'b00010);
    cycle(5'b00000, 5'b00000);

    // Reset right after MUL1 is granted: its broadcast is dropped and arbitration restarts at 0.
    cycle(5'b01000, 5'b01000);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.req_valid = 5'b11000;
    #1;
    check("midreset_cdb_valid", bus.cdb_valid, 0);
    check("midreset_grant",     bus.grant,     0);
    sb.delete();
    exp_count = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("post_reset_grant", bus.grant, 5'b01000);
    push_exp(3);
    cycle(5'b10000, 5'b10000);
    cycle(5'b00000, 5'b00000);

    // ADD1 and MUL2 together straight after reset.
    do_reset();
`ifdef CDB_MUL_PRIORITY_EN
    cycle(5'b10001, 5'b10000);
    cycle(5'b00001, 5'b00001);
`else
    cycle(5'b10001, 5'b00001);
    cycle(5'b10000, 5'b10000);
`endif
    cycle(5'b00000, 5'b00000);

    // Broadcast counter saturates at 16'hFFFF.
    do_reset();
    repeat (65540) cycle(5'b00001, 5'b00001);
    cycle(5'b00000, 5'b00000);
    cycle(5'b00000, 5'b00000);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common Data Bus (CDB) arbiter sitting directly downstream of the arithmetic unit's adders and multipliers.
- Collects finished results from up to NUM_UNITS functional units and grants exactly one per cycle.
- Broadcasts the winner's tag and value on a registered CDB that reservation stations and the register status table snoop.
- Uses round-robin arbitration so that no unit starves.

Parameters:
- NUM_UNITS, 5, number of result producers: index 0-2 are ADD1-ADD3, index 3-4 are MUL1-MUL2.
- DATA_W, 32, result width.
- TAG_W, 4, CDB tag width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_UNITS  per-unit "result ready" flag, held high until granted
- req_data  input  NUM_UNITS*DATA_W  per-unit result; unit i occupies bits [i*DATA_W +: DATA_W]
- grant  output  NUM_UNITS  combinational one-hot grant for the current cycle
- cdb_valid  output  1  registered broadcast valid
- cdb_tag  output  TAG_W  registered producer tag, equal to unit index + 1
- cdb_data  output  DATA_W  registered broadcast value
- cdb_count  output  16  registered count of broadcasts since reset

Behaviour:
- Clock and reset: clk is the clock. reset is asynchronous and active-high.
- Reset values:
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_count=0.
  - Round-robin pointer rr_ptr=0.
  - grant forced to 0 while reset is high.
- Tag encoding: tag 0 is reserved to mean "no producer / operand ready". Unit i broadcasts tag i+1, so ADD1=1 and MUL2=5.
- Handshake:
  - A unit raises req_valid[i] with stable req_data.
  - A transfer occurs on the rising edge where req_valid[i] and grant[i] are both high.
  - The unit must drop req_valid[i], or present a new result, in the cycle after that edge.
  - The arbiter never re-grants the same request, because the unit has already withdrawn it.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_UNITS.
  - The first set bit wins; grant is one-hot or all zero.
- Latency: one cycle. A request granted at edge t appears as cdb_valid=1, cdb_tag=winner+1, cdb_data=req_data[winner] during cycle t+1.
- Pointer update:
  - On a transfer, rr_ptr becomes winner+1, wrapping NUM_UNITS-1 to 0.
  - With no transfer, rr_ptr holds.
- Idle cycles: if no requests are present, cdb_valid=0 next cycle, and cdb_tag and cdb_data are driven to 0 (not held).
- Back-to-back broadcasts: a new transfer every cycle is allowed, and cdb_valid stays high continuously.
- Simultaneous requests: exactly one winner per cycle. Losers stay pending and are served in pointer order. Worst-case wait is NUM_UNITS-1 cycles.
- cdb_count: increments by 1 per transfer and saturates at 16'hFFFF.
- Reset mid-operation: any in-flight broadcast is dropped. Pending requests remain on the inputs and are arbitrated from index 0 after reset deasserts.
- Illegal input: X on a req_valid bit is flagged by an assertion only.

Optional Feature:
- Macro: CDB_MUL_PRIORITY_EN.
- When defined: any requesting multiplier (index >= 3) beats all adders. Round-robin then applies only within the multiplier group, and only within the adder group when no multiplier requests. There are two pointers, rr_add and rr_mul, both reset to the group base.
- When undefined: a single flat round-robin across all units, as described above.
- Tag, latency and handshake are identical in both builds.

Decomposition:
- Shared package tomasulo_pkg holds:
  - TAG_W.
  - Tag constants TAG_NONE=0, TAG_ADD1=1 .. TAG_MUL2=5.
  - NUM_ADD=3 and NUM_MUL=2.
  - A packed cdb_t struct {valid, tag, data} used by the reservation stations and register status logic.
- Sub-module rr_pick:
  - Purely combinational: request vector plus start pointer in, one-hot grant plus winner index out.
  - Instantiated once in the flat build, and twice (adder group, multiplier group) when CDB_MUL_PRIORITY_EN is defined.

Test Plan:
- Single request: reset, then req_valid=5'b00001 with data 32'h0000_0011.
  - grant=00001 in the same cycle.
  - Next cycle: cdb_valid=1, cdb_tag=1, cdb_data=32'h11, cdb_count=1.
- All five units request simultaneously and each drops on grant.
  - Broadcast tags are 1,2,3,4,5 on five consecutive cycles with cdb_valid continuously high.
  - rr_ptr ends at 0, and cdb_count=5.
- Fairness: unit 0 re-requests every cycle and unit 2 requests once.
  - Unit 2 is granted within 2 cycles; expected tag sequence 1,3,1.
- Wrap-around: rr_ptr=4, requests from units 4 and 0.
  - Tag 5 then tag 1, and rr_ptr wraps to 1.
- Reset mid-operation: assert reset one cycle after a grant to unit 3.
  - cdb_valid=0 immediately with no tag-4 broadcast.
  - After release with unit 3 still requesting, grant=01000 and the next cycle cdb_tag=4.
- With CDB_MUL_PRIORITY_EN: units 0 and 4 request together.
  - Tag 5 is broadcast first, then tag 1.
  - Without the macro the same stimulus gives tag 1 then tag 5.
